// File: rtl/usb_ctrl_pkg.sv
// Shared types and constants for the USB control-packet receiver.
package usb_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_CHECK,
        ST_COMMIT
    } state_e;

    localparam logic [7:0] SYNC_DEF = 8'hA5;

    localparam int EN_OFF   = 0;
    localparam int GAIN_OFF = 8;
    localparam int GAIN_W   = 16;
    localparam int OFF_OFF  = 24;
    localparam int OFF_W    = 16;

    localparam int MIN_PKT_BYTES = 5;

    function automatic int pkt_len(input int pkt_bytes);
`ifdef USB_CTRL_RX_CSUM_EN
        return 1 + pkt_bytes + 1;
`else
        return 1 + pkt_bytes;
`endif
    endfunction

endpackage

// File: rtl/usb_ctrl_rx_csum8.sv
// 8-bit running-sum accumulator (mod 256) with synchronous clear and enable.
module ctrl_csum8 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       en,
    input  logic [7:0] din,
    output logic [7:0] sum
);

    logic [7:0] sum_q;
    logic [7:0] sum_d;

    always_comb begin
        sum_d = sum_q;
        if (clr) begin
            sum_d = 8'h00;
        end else if (en) begin
            sum_d = sum_q + din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q <= 8'h00;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign sum = sum_q;

endmodule

// File: rtl/usb_ctrl_rx.sv
// Control-packet receiver: pops framed packets from the USB FIFO, commits valid ones.
// Define USB_CTRL_RX_CSUM_EN to require and check a trailing checksum byte.
module usb_ctrl_rx
    import usb_ctrl_pkg::*;
#(
    parameter int         PKT_BYTES = 32,
    parameter int         CNT_W     = 8,
    parameter logic [7:0] SYNC_BYTE = SYNC_DEF,
    parameter int         ERR_W     = 16
) (
    input  logic                   clk_100M,
    input  logic                   nrst,
    output logic                   usb_rd_valid,
    input  logic [7:0]             usb_readdata,
    input  logic [CNT_W-1:0]       usb_rxbytes,
    output logic                   usb_rd_clk,
    output logic [PKT_BYTES*8-1:0] cont_reg,
    output logic                   cont_en,
    output logic [GAIN_W-1:0]      cont_gain,
    output logic [OFF_W-1:0]       cont_off,
    output logic                   pkt_ok,
    output logic                   pkt_err,
    output logic [ERR_W-1:0]       err_cnt
);

    localparam int PKT_LEN = pkt_len(PKT_BYTES);
    localparam logic [CNT_W-1:0] LEN_C    = CNT_W'(PKT_LEN);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(PKT_LEN - 1);
    localparam logic [CNT_W-1:0] PAY_END  = CNT_W'(PKT_BYTES);

    state_e                 state_q, state_d;
    logic                   rd_valid_q, rd_valid_d;
    logic [CNT_W-1:0]       idx_q, idx_d;
    logic [PKT_BYTES*8-1:0] shadow_q, shadow_d;
    logic [PKT_BYTES*8-1:0] cont_q, cont_d;
    logic                   pkt_ok_q, pkt_ok_d;
    logic                   pkt_err_q, pkt_err_d;
    logic [ERR_W-1:0]       err_cnt_q, err_cnt_d;
    logic                   csum_ok;

`ifdef USB_CTRL_RX_CSUM_EN
    logic [7:0] csum_q, csum_d;
    logic [7:0] acc_sum;
    logic       acc_clr;
    logic       acc_en;

    ctrl_csum8 u_csum (
        .clk   (clk_100M),
        .rst_n (nrst),
        .clr   (acc_clr),
        .en    (acc_en),
        .din   (usb_readdata),
        .sum   (acc_sum)
    );

    assign csum_ok = (csum_q == acc_sum);
`else
    assign csum_ok = 1'b1;
`endif

    always_comb begin
        state_d    = state_q;
        rd_valid_d = rd_valid_q;
        idx_d      = idx_q;
        shadow_d   = shadow_q;
        cont_d     = cont_q;
        pkt_ok_d   = 1'b0;
        pkt_err_d  = 1'b0;
        err_cnt_d  = err_cnt_q;
`ifdef USB_CTRL_RX_CSUM_EN
        csum_d  = csum_q;
        acc_clr = 1'b0;
        acc_en  = 1'b0;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (usb_rxbytes >= LEN_C) begin
                    rd_valid_d = 1'b1;
                    idx_d      = '0;
                    state_d    = ST_READ;
`ifdef USB_CTRL_RX_CSUM_EN
                    acc_clr = 1'b1;
`endif
                end
            end
            ST_READ: begin
                if (idx_q == '0) begin
                    // a bad sync costs exactly one byte so the stream resyncs bytewise
                    if (usb_readdata != SYNC_BYTE) begin
                        rd_valid_d = 1'b0;
                        pkt_err_d  = 1'b1;
                        state_d    = ST_IDLE;
                    end else begin
                        idx_d = idx_q + CNT_W'(1);
                    end
                end else begin
                    for (int i = 0; i < PKT_BYTES; i++) begin
                        if (idx_q == CNT_W'(i + 1)) begin
                            shadow_d[i*8 +: 8] = usb_readdata;
                        end
                    end
`ifdef USB_CTRL_RX_CSUM_EN
                    acc_en = (idx_q <= PAY_END);
                    if (idx_q > PAY_END) begin
                        csum_d = usb_readdata;
                    end
`endif
                    if (idx_q == LAST_IDX) begin
                        rd_valid_d = 1'b0;
                        state_d    = ST_CHECK;
                    end else begin
                        idx_d = idx_q + CNT_W'(1);
                    end
                end
            end
            ST_CHECK: begin
                if (csum_ok) begin
                    state_d = ST_COMMIT;
                end else begin
                    pkt_err_d = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            ST_COMMIT: begin
                cont_d   = shadow_q;
                pkt_ok_d = 1'b1;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (pkt_err_d && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + ERR_W'(1);
        end
    end

    always_ff @(posedge clk_100M or negedge nrst) begin
        if (!nrst) begin
            state_q    <= ST_IDLE;
            rd_valid_q <= 1'b0;
            idx_q      <= '0;
            shadow_q   <= '0;
            cont_q     <= '0;
            pkt_ok_q   <= 1'b0;
            pkt_err_q  <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            rd_valid_q <= rd_valid_d;
            idx_q      <= idx_d;
            shadow_q   <= shadow_d;
            cont_q     <= cont_d;
            pkt_ok_q   <= pkt_ok_d;
            pkt_err_q  <= pkt_err_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

`ifdef USB_CTRL_RX_CSUM_EN
    always_ff @(posedge clk_100M or negedge nrst) begin
        if (!nrst) begin
            csum_q <= 8'h00;
        end else begin
            csum_q <= csum_d;
        end
    end
`endif

    assign usb_rd_valid = rd_valid_q;
    assign usb_rd_clk   = clk_100M;
    assign cont_reg     = cont_q;
    assign cont_en      = cont_q[EN_OFF];
    assign cont_gain    = cont_q[GAIN_OFF +: GAIN_W];
    assign cont_off     = cont_q[OFF_OFF +: OFF_W];
    assign pkt_ok       = pkt_ok_q;
    assign pkt_err      = pkt_err_q;
    assign err_cnt      = err_cnt_q;

endmodule
